// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter: FSM state encoding,
// default parameter values and width helpers used by fifo_write_arb and
// its round-robin picker rr_pick.
package fifo_arb_pkg;

    // Two-state burst FSM: waiting for a request, or moving a burst.
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arbState_t;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_MAX = 16;

    // Word counter must be able to hold BURST_MAX itself.
    localparam int CNT_W = $clog2(DEF_BURST_MAX + 1);

    // Width of a requester index; a single requester still needs one bit.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arb_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Starting at index rr_ptr and
// searching upward with wrap-around, returns the first asserted request
// as a one-hot winner, or zero when no request is asserted.
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   PTRW     highest-priority index this round
//   winner  out  NUM_REQ  one-hot winner or zero
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTRW    = ptrWidth(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTRW-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] winner
);

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr is always below NUM_REQ, so one subtraction wraps.
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arb.sv
// fifo_write_arb
// Arbitrates NUM_REQ word sources onto the write side of a dual-clock FIFO.
// A round-robin winner is registered as grant in IDLE; in XFER the owner's
// words are passed straight through whenever the FIFO is not full. A burst
// ends on last, on reaching BURST_MAX words, or when the owner drops req.
//   wclk        in   1                  write-domain clock
//   w_reset     in   1                  asynchronous active-high reset
//   req         in   NUM_REQ            per-requester word valid
//   last        in   NUM_REQ            per-requester end-of-burst marker
//   din_bus     in   NUM_REQ*DATAWIDTH  requester words, i at [i*DATAWIDTH +: DATAWIDTH]
//   ack         out  NUM_REQ            word accepted this cycle
//   grant       out  NUM_REQ            registered one-hot owner
//   fifo_full   in   1                  FIFO full flag
//   fifo_write  out  1                  FIFO write strobe
//   fifo_din    out  DATAWIDTH          FIFO write data
//   busy        out  1                  high while in XFER
module fifo_write_arb
    import fifo_arb_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                         wclk,
    input  logic                         w_reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           last,
    input  logic [NUM_REQ*DATAWIDTH-1:0] din_bus,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           grant,
    input  logic                         fifo_full,
    output logic                         fifo_write,
    output logic [DATAWIDTH-1:0]         fifo_din,
    output logic                         busy
);

    localparam int PTRW = ptrWidth(NUM_REQ);
    localparam int CNTW = $clog2(BURST_MAX + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST_MAX - 1);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(NUM_REQ - 1);

    arbState_t          state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTRW-1:0]    rrPtr_q, rrPtr_d;
    logic [CNTW-1:0]    count_q, count_d;

    logic [NUM_REQ-1:0] winner;
    logic [PTRW-1:0]    grantIdx;
    logic               ownerReq;
    logic               ownerLast;
    logic               accept;
    logic               burstEnd;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTRW    (PTRW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rrPtr_q),
        .winner (winner)
    );

    // Owner-side view of the inputs. grant_q is zero outside XFER, so these
    // are naturally inactive in IDLE. An accepted word that is last or that
    // fills the burst ends it; so does the owner withdrawing its request,
    // even while the FIFO is full.
    always_comb begin
        ownerReq  = |(req & grant_q);
        ownerLast = |(last & grant_q);
        accept    = (state_q == XFER) && ownerReq && !fifo_full;
        burstEnd  = (state_q == XFER) &&
                    (!ownerReq || (accept && (ownerLast || (count_q == CNT_LAST))));
        grantIdx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                grantIdx = PTRW'(i);
            end
        end
    end

    // State register; reset clears everything so outputs drop immediately.
    always_ff @(posedge wclk or posedge w_reset) begin
        if (w_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rrPtr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rrPtr_q <= rrPtr_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: register the winner on entry, count accepted words,
    // and hand priority to the requester after the owner when a burst ends.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rrPtr_d = rrPtr_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = XFER;
                    grant_d = winner;
                    count_d = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                end
                if (burstEnd) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rrPtr_d = (grantIdx == PTR_LAST) ? '0 : grantIdx + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: writes pass through combinationally from the owner; data is
    // masked by grant so fifo_din is zero whenever nobody owns the bus.
    always_comb begin
        ack        = accept ? grant_q : '0;
        fifo_write = accept;
        busy       = (state_q == XFER);
        grant      = grant_q;
        fifo_din   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                fifo_din = fifo_din | din_bus[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_arb.sv
// tb_fifo_write_arb
// Randomized and directed stimulus against a transaction-level model of
// the arbiter. The stimulus side predicts each cycle's outputs and every
// FIFO write into queues; an independent monitor pops and compares them.
module tb_fifo_write_arb;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int BM = 16;

    logic             wclk = 1'b0;
    logic             w_reset;
    logic [NR-1:0]    req;
    logic [NR-1:0]    last;
    logic [NR*DW-1:0] din_bus;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    grant;
    logic             fifo_full;
    logic             fifo_write;
    logic [DW-1:0]    fifo_din;
    logic             busy;

    fifo_write_arb #(
        .DATAWIDTH (DW),
        .NUM_REQ   (NR),
        .BURST_MAX (BM)
    ) dut (
        .wclk       (wclk),
        .w_reset    (w_reset),
        .req        (req),
        .last       (last),
        .din_bus    (din_bus),
        .ack        (ack),
        .grant      (grant),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_din   (fifo_din),
        .busy       (busy)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [NR-1:0] grant;
        logic          busy;
        logic [NR-1:0] ack;
        logic          write;
        logic [DW-1:0] din;
    } cycExp_t;

    cycExp_t       stateQ[$];
    logic [DW-1:0] writeQ[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the bus (-1 = nobody), words moved in the
    // current burst, and the requester that gets first look next round.
    int owner = -1;
    int cnt   = 0;
    int ptr   = 0;

    // Sources: each requester emits an incrementing word stream, advancing
    // only when the model says its word was taken.
    logic [DW-1:0] srcData[NR];
    int            srcIdx[NR];
    int            lastEvery = 0;
    int            pLast     = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic [NR-1:0] reqV, input logic fullV);
        cycExp_t       e;
        logic [NR-1:0] lastV;
        bit            found;
        bit            endB;
        int            g;
        for (int i = 0; i < NR; i++) begin
            if (lastEvery > 0) begin
                lastV[i] = ((srcIdx[i] % lastEvery) == (lastEvery - 1));
            end else begin
                lastV[i] = ($urandom_range(99) < pLast);
            end
            din_bus[i*DW +: DW] = srcData[i];
        end
        w_reset   = rstV;
        req       = reqV;
        last      = lastV;
        fifo_full = fullV;

        e.grant = '0;
        e.busy  = 1'b0;
        e.ack   = '0;
        e.write = 1'b0;
        e.din   = '0;
        if (rstV) begin
            owner = -1;
            cnt   = 0;
            ptr   = 0;
        end else if (owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!found && reqV[(ptr + k) % NR]) begin
                    owner = (ptr + k) % NR;
                    cnt   = 0;
                    found = 1'b1;
                end
            end
        end else begin
            g       = owner;
            e.grant = NR'(1) << g;
            e.busy  = 1'b1;
            e.din   = srcData[g];
            endB    = 1'b0;
            if (reqV[g] && !fullV) begin
                e.ack   = NR'(1) << g;
                e.write = 1'b1;
                writeQ.push_back(srcData[g]);
                srcData[g] = srcData[g] + 1'b1;
                srcIdx[g]++;
                cnt++;
                endB = lastV[g] || (cnt == BM);
            end else if (!reqV[g]) begin
                endB = 1'b1;
            end
            if (endB) begin
                owner = -1;
                ptr   = (g + 1) % NR;
            end
        end
        stateQ.push_back(e);
        @(posedge wclk);
        #1;
    endtask

    // Monitor: one prediction per cycle, checked mid-cycle; every write the
    // DUT presents must match the next predicted word.
    initial begin
        cycExp_t e;
        forever begin
            @(negedge wclk);
            if (stateQ.size() > 0) begin
                e = stateQ.pop_front();
                checkOutput("grant", 32'(grant), 32'(e.grant));
                checkOutput("busy", 32'(busy), 32'(e.busy));
                checkOutput("ack", 32'(ack), 32'(e.ack));
                checkOutput("fifo_write", 32'(fifo_write), 32'(e.write));
                checkOutput("fifo_din", 32'(fifo_din), 32'(e.din));
                if (fifo_write) begin
                    if (writeQ.size() == 0) begin
                        checkOutput("spurious_write", 32'(fifo_write), 32'd0);
                    end else begin
                        checkOutput("write_data", 32'(fifo_din), 32'(writeQ.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            srcData[i] = 8'h90 + 8'(i * 16);
            srcIdx[i]  = 0;
        end
        w_reset   = 1'b1;
        req       = '0;
        last      = '0;
        din_bus   = '0;
        fifo_full = 1'b0;
        @(posedge wclk);
        #1;

        // Reset state.
        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0);

        // Single burst from requester 1, words 0xA0..0xA3 with last on 0xA3.
        lastEvery = 4;
        repeat (6) applyStimulus(1'b0, 4'b0010, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b0000, 1'b0);

        // Fairness: everyone requesting, two-word bursts.
        lastEvery = 2;
        for (int i = 0; i < NR; i++) srcIdx[i] = 0;
        repeat (20) applyStimulus(1'b0, 4'b1111, 1'b0);
        repeat (2) applyStimulus(1'b0, 4'b0000, 1'b0);

        // Burst cap: no last at all, requesters 2 and 3 alternate at BM words.
        lastEvery = 0;
        pLast     = 0;
        repeat (40) applyStimulus(1'b0, 4'b1100, 1'b0);
        repeat (2) applyStimulus(1'b0, 4'b0000, 1'b0);

        // Backpressure: three full cycles in the middle of a burst.
        repeat (3) applyStimulus(1'b0, 4'b0001, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b0001, 1'b1);
        repeat (3) applyStimulus(1'b0, 4'b0001, 1'b0);
        repeat (2) applyStimulus(1'b0, 4'b0000, 1'b0);

        // Abort: requester 0 drops after two words.
        repeat (3) applyStimulus(1'b0, 4'b0001, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b0000, 1'b0);

        // Reset mid-burst, then arbitration restarts at requester 0.
        repeat (4) applyStimulus(1'b0, 4'b0001, 1'b0);
        repeat (2) applyStimulus(1'b1, 4'b0001, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b1010, 1'b0);

        // Random traffic with backpressure, last and occasional aborts.
        pLast = 25;
        repeat (400) begin
            logic [NR-1:0] r;
            for (int i = 0; i < NR; i++) r[i] = ($urandom_range(99) < 85);
            applyStimulus(1'b0, r, ($urandom_range(99) < 30));
        end

        // Random traffic with sporadic resets.
        repeat (300) begin
            logic [NR-1:0] r;
            for (int i = 0; i < NR; i++) r[i] = ($urandom_range(99) < 70);
            applyStimulus(($urandom_range(99) < 3), r, ($urandom_range(99) < 20));
        end
        applyStimulus(1'b0, 4'b0000, 1'b0);

        @(negedge wclk);
        checkOutput("write_queue_drained", 32'(writeQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
